// File: rtl/gc_ptr_sync.sv
// Receive-side Gray pointer synchronizer: sync chain, Gray->binary decode, and registered fill level/flags.
// Optional sticky illegal-Gray-step detection is enabled by defining GC_CHECK_EN.
module gc_ptr_sync #(
    parameter int unsigned W           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AFULL       = 192
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic [W-1:0] gc_in,
    input  logic [W-1:0] local_ptr,
    output logic [W-1:0] ptr_bin,
    output logic [W-1:0] level,
    output logic         empty,
    output logic         almost_full,
    output logic         gc_err
);

    // Gray {1,0..0} decodes to binary all-ones, matching the counter's cleared state
    localparam logic [W-1:0] GC_RST  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] AFULL_W = W'(AFULL);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  gc_sync;
    logic [W-1:0]                  ptr_d, ptr_q;
    logic [W-1:0]                  level_d, level_q;
    logic                          empty_q, afull_q;

    assign gc_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{GC_RST}};
        end else if (clear) begin
            sync_q <= {SYNC_STAGES{GC_RST}};
        end else begin
            sync_q[0] <= gc_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        ptr_d = '0;
        for (int unsigned i = 0; i < W; i++) begin
            ptr_d[i] = ^(gc_sync >> i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '1;
        end else if (clear) begin
            ptr_q <= '1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign level_d = ptr_q - local_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= '0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
        end else if (clear) begin
            level_q <= '0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            empty_q <= (ptr_q == local_ptr);
            afull_q <= (level_d >= AFULL_W);
        end
    end

`ifdef GC_CHECK_EN
    logic [W-1:0] prev_q;
    logic         err_q;
    logic         step_bad;

    assign step_bad = ($countones(gc_sync ^ prev_q) > 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q <= GC_RST;
            err_q  <= 1'b0;
        end else if (clear) begin
            prev_q <= GC_RST;
            err_q  <= 1'b0;
        end else begin
            prev_q <= gc_sync;
            err_q  <= err_q | step_bad;
        end
    end

    assign gc_err = err_q;
`else
    assign gc_err = 1'b0;
`endif

    assign ptr_bin     = ptr_q;
    assign level       = level_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;

endmodule

// File: tb/tb_gc_ptr_sync.sv
// Testbench for gc_ptr_sync: directed vector table plus randomized Gray traffic against a sample-history model.
module tb_gc_ptr_sync;

    localparam int unsigned W  = 8;
    localparam int unsigned SS = 2;
    localparam logic [7:0]  AF = 8'd192;
`ifdef GC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] gc_in = 8'h80;
    logic [7:0] local_ptr = 8'hFF;
    logic [7:0] ptr_bin, level;
    logic       empty, almost_full, gc_err;

    always #5 clk = ~clk;

    gc_ptr_sync #(.W(W), .SYNC_STAGES(SS), .AFULL(192)) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .gc_in(gc_in), .local_ptr(local_ptr),
        .ptr_bin(ptr_bin), .level(level), .empty(empty), .almost_full(almost_full), .gc_err(gc_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: history of Gray samples seen at each edge; outputs derived from delayed samples
    logic [7:0] hist[$];
    logic [7:0] m_ptr, m_lvl;
    bit         m_empty, m_af, m_err;

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b = '0;
        for (int k = 0; k < 8; k++) b = b ^ (g >> k);
        return b;
    endfunction

    task automatic model_clear();
        hist.delete();
        repeat (SS + 2) hist.push_back(8'h80);
        m_ptr = 8'hFF; m_lvl = 8'h00; m_empty = 1'b1; m_af = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input bit clr, input logic [7:0] g, input logic [7:0] lp);
        if (clr) begin
            model_clear();
        end else begin
            hist.push_back(g);
            while (hist.size() > SS + 2) void'(hist.pop_front());
            m_lvl   = g2b(hist[0]) - lp;
            m_empty = (m_lvl == 8'h00);
            m_af    = (m_lvl >= AF);
            m_ptr   = g2b(hist[1]);
            if (CHK && ($countones(hist[1] ^ hist[0]) > 1)) m_err = 1'b1;
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    task automatic check_model();
        chk8("ptr_bin/model", ptr_bin, m_ptr);
        chk8("level/model", level, m_lvl);
        chk1("empty/model", empty, m_empty);
        chk1("almost_full/model", almost_full, m_af);
        chk1("gc_err/model", gc_err, m_err);
    endtask

    task automatic step(input bit clr, input logic [7:0] g, input logic [7:0] lp);
        clear = clr; gc_in = g; local_ptr = lp;
        @(posedge clk);
        model_edge(clr, g, lp);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         clr;
        logic [7:0] g;
        logic [7:0] lp;
        bit         chk;
        logic [7:0] ep;
        logic [7:0] el;
        bit         ee;
        bit         eaf;
        bit         eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit clr, logic [7:0] g, logic [7:0] lp, bit c,
                                logic [7:0] ep, logic [7:0] el, bit ee, bit eaf, bit eerr);
        vec_t v;
        v.clr = clr; v.g = g; v.lp = lp; v.chk = c;
        v.ep = ep; v.el = el; v.ee = ee; v.eaf = eaf; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        logic [7:0] rb, lb;

        // Post-reset state and the 80->00 latency check
        repeat (2) tbl.push_back(mk(0, 8'h80, 8'hFF, 1, 8'hFF, 8'h00, 1, 0, 0));
        repeat (2) tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 8'h01, 0, 0, 0));
        // Wrap: Gray 03 (bin 02) against local FE; 00->03 is a two-bit step
        repeat (4) tbl.push_back(mk(0, 8'h03, 8'hFE, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h03, 8'hFE, 1, 8'h02, 8'h04, 0, 0, CHK));
        // Almost-full threshold
        repeat (4) tbl.push_back(mk(0, 8'hE0, 8'hFF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'hE0, 8'hFF, 1, 8'hBF, 8'hC0, 0, 1, CHK));
        repeat (4) tbl.push_back(mk(0, 8'hA0, 8'hFF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'hA0, 8'hFF, 1, 8'hC0, 8'hC1, 0, 1, CHK));
        tbl.push_back(mk(0, 8'hA0, 8'h00, 1, 8'hC0, 8'hC0, 0, 1, CHK));
        // Clear mid-run from level 5
        repeat (4) tbl.push_back(mk(0, 8'h03, 8'hFD, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h03, 8'hFD, 1, 8'h02, 8'h05, 0, 0, CHK));
        tbl.push_back(mk(1, 8'h80, 8'hFF, 1, 8'hFF, 8'h00, 1, 0, 0));
        repeat (4) tbl.push_back(mk(0, 8'h80, 8'hFF, 1, 8'hFF, 8'h00, 1, 0, 0));
        // Illegal step 00->03, sticky through a legal step, cleared by clear
        repeat (2) tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'hFF, 1, 8'h00, 8'h01, 0, 0, 0));
        repeat (2) tbl.push_back(mk(0, 8'h03, 8'hFF, 1, 8'h00, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 8'h03, 8'hFF, 1, 8'h02, 8'h01, 0, 0, CHK));
        repeat (2) tbl.push_back(mk(0, 8'h02, 8'hFF, 1, 8'h02, 8'h03, 0, 0, CHK));
        tbl.push_back(mk(0, 8'h02, 8'hFF, 1, 8'h03, 8'h03, 0, 0, CHK));
        tbl.push_back(mk(0, 8'h02, 8'hFF, 1, 8'h03, 8'h04, 0, 0, CHK));
        tbl.push_back(mk(1, 8'h80, 8'hFF, 1, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h80, 8'hFF, 1, 8'hFF, 8'h00, 1, 0, 0));

        // Reset
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk8("reset ptr_bin", ptr_bin, 8'hFF);
        chk8("reset level", level, 8'h00);
        chk1("reset empty", empty, 1'b1);
        chk1("reset almost_full", almost_full, 1'b0);
        chk1("reset gc_err", gc_err, 1'b0);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].g, tbl[i].lp);
            if (tbl[i].chk) begin
                chk8($sformatf("vec%0d ptr_bin", i), ptr_bin, tbl[i].ep);
                chk8($sformatf("vec%0d level", i), level, tbl[i].el);
                chk1($sformatf("vec%0d empty", i), empty, tbl[i].ee);
                chk1($sformatf("vec%0d almost_full", i), almost_full, tbl[i].eaf);
                chk1($sformatf("vec%0d gc_err", i), gc_err, tbl[i].eerr);
            end
        end

        // Random Gray traffic with occasional clears and one async reset
        rb = 8'hFF;
        lb = 8'hFF;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge clk);
                rstn = 1'b0;
                model_clear();
                repeat (2) @(posedge clk);
                #1;
                check_model();
                rstn = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) begin
                rb = 8'hFF;
                step(1'b1, 8'h80, lb);
            end else begin
                if ($urandom_range(0, 1) == 1) rb = rb + 8'd1;
                if ($urandom_range(0, 3) == 0) lb = 8'($urandom);
                else if ($urandom_range(0, 1) == 1) lb = lb + 8'd1;
                step(1'b0, rb ^ (rb >> 1), lb);
            end
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
